// File: rtl/sha_1_pad_if.sv
// Byte stream in, 512-bit blocks out to a SHA-1 core, digest back out.
interface sha_1_pad_if;
    logic [7:0]   s_data;
    logic         s_valid;
    logic         s_last;
    logic         s_empty;
    logic         s_ready;
    logic [511:0] blk_data;
    logic [63:0]  blk_index;
    logic         blk_enable;
    logic         core_ready;
    logic [159:0] core_hash;
    logic [159:0] digest;
    logic         done;

    // Padder side
    modport slave (
        input  s_data, s_valid, s_last, s_empty, core_ready, core_hash,
        output s_ready, blk_data, blk_index, blk_enable, digest, done
    );

    // Message source / core side
    modport master (
        output s_data, s_valid, s_last, s_empty, core_ready, core_hash,
        input  s_ready, blk_data, blk_index, blk_enable, digest, done
    );
endinterface

// File: rtl/sha_1_pad.sv
// SHA-1 message padder: packs bytes big-endian into 512-bit blocks, appends
// 0x80, zero fill and the 64-bit bit length, hands each block to the core and
// forwards the final chaining value as the digest.
//
// state | meaning
// FILL  | accepting message bytes (s_ready=1)
// PAD   | write 0x80 terminator, zero fill, length if it fits
// LEN   | extra block holding only the bit length
// SEND  | blk_enable pulse, block presented to core
// WAIT  | block held until the core reports completion
module sha_1_pad (
    input  logic        clk,
    input  logic        rst,
    sha_1_pad_if.slave  io_bus
);
    typedef enum logic [2:0] {FILL, PAD, LEN, SEND, WAIT} state_t;

    state_t         r_state;
    logic [511:0]   r_buf;
    logic [5:0]     r_pos;
    logic [60:0]    r_count;
    logic [63:0]    r_index;
    logic           r_final;
    logic           r_pad_pending;
    logic           r_len_pending;
    logic           r_blk_enable;
    logic           r_done;
    logic [159:0]   r_digest;

    logic [63:0]    w_len;
    logic [63:0]    w_len_field;
    logic [8:0]     w_ofs;
    logic [511:0]   w_fill_buf;
    logic [511:0]   w_pad_buf;
    logic [511:0]   w_len_buf;

    // Bytes 56..63 live in words 14 and 15, so the big-endian length splits
    // across them with its upper half in word 14.
    assign w_len       = {r_count, 3'b000};
    assign w_len_field = {w_len[31:0], w_len[63:32]};
    assign w_ofs       = {r_pos[5:2], ~r_pos[1:0], 3'b000};
    assign w_len_buf   = {w_len_field, 448'd0};

    // Current buffer with the incoming byte dropped into slot r_pos
    always_comb begin
        w_fill_buf = r_buf;
        w_fill_buf[w_ofs +: 8] = io_bus.s_data;
    end

    // Terminator at r_pos, zeros after it, length when 8 bytes remain free
    always_comb begin
        w_pad_buf = r_buf;
        for (int k = 0; k < 64; k++) begin
            if (6'(k) == r_pos)
                w_pad_buf[(k / 4) * 32 + (3 - (k % 4)) * 8 +: 8] = 8'h80;
            else if (6'(k) > r_pos)
                w_pad_buf[(k / 4) * 32 + (3 - (k % 4)) * 8 +: 8] = 8'h00;
        end
        if (r_pos <= 6'd55)
            w_pad_buf[511:448] = w_len_field;
    end

    // Sequencer: byte packing, padding, block handoff and digest capture
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= FILL;
            r_buf         <= '0;
            r_pos         <= '0;
            r_count       <= '0;
            r_index       <= 64'd1;
            r_final       <= 1'b0;
            r_pad_pending <= 1'b0;
            r_len_pending <= 1'b0;
            r_blk_enable  <= 1'b0;
            r_done        <= 1'b0;
            r_digest      <= '0;
        end else begin
            r_blk_enable <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                FILL: begin
                    if (io_bus.s_valid) begin
                        if (io_bus.s_empty) begin
                            if (io_bus.s_last)
                                r_state <= PAD;
                        end else begin
                            r_buf   <= w_fill_buf;
                            r_pos   <= r_pos + 6'd1;
                            r_count <= r_count + 61'd1;
                            if (r_pos == 6'd63) begin
                                // Full block goes out first; padding follows in a fresh block
                                r_pad_pending <= io_bus.s_last;
                                r_blk_enable  <= 1'b1;
                                r_state       <= SEND;
                            end else if (io_bus.s_last) begin
                                r_state <= PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    r_buf <= w_pad_buf;
                    if (r_pos <= 6'd55)
                        r_final <= 1'b1;
                    else
                        r_len_pending <= 1'b1;
                    r_blk_enable <= 1'b1;
                    r_state      <= SEND;
                end
                LEN: begin
                    r_buf        <= w_len_buf;
                    r_final      <= 1'b1;
                    r_blk_enable <= 1'b1;
                    r_state      <= SEND;
                end
                SEND: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (io_bus.core_ready) begin
                        r_pos <= '0;
                        r_buf <= '0;
                        if (r_final) begin
                            r_digest      <= io_bus.core_hash;
                            r_done        <= 1'b1;
                            r_count       <= '0;
                            r_index       <= 64'd1;
                            r_final       <= 1'b0;
                            r_pad_pending <= 1'b0;
                            r_len_pending <= 1'b0;
                            r_state       <= FILL;
                        end else begin
                            r_index <= r_index + 64'd1;
                            if (r_pad_pending) begin
                                r_pad_pending <= 1'b0;
                                r_state       <= PAD;
                            end else if (r_len_pending) begin
                                r_len_pending <= 1'b0;
                                r_state       <= LEN;
                            end else begin
                                r_state <= FILL;
                            end
                        end
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign io_bus.s_ready    = (r_state == FILL);
    assign io_bus.blk_data   = r_buf;
    assign io_bus.blk_index  = r_index;
    assign io_bus.blk_enable = r_blk_enable;
    assign io_bus.digest     = r_digest;
    assign io_bus.done       = r_done;
endmodule

// File: doc/sha_1_pad.md
SHA_1_PAD -- requirements
Module: sha_1_pad

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 rst  in  1  reset, synchronous, active-low.
REQ-003 s_data  in  8  message byte, first byte first.
REQ-004 s_valid  in  1  s_data/s_last/s_empty valid.
REQ-005 s_last  in  1  final beat of message.
REQ-006 s_empty  in  1  with s_last: beat carries no byte (zero-length tail or empty message).
REQ-007 s_ready  out  1  byte accepted when s_valid&s_ready.
REQ-008 blk_data  out  512  block to core; word i = blk_data[i*32+:32], byte k at word k/4, bits (3-k%4)*8+:8 (big-endian).
REQ-009 blk_index  out  64  block number within message, first block = 1.
REQ-010 blk_enable  out  1  one-cycle start pulse to core.
REQ-011 core_ready  in  1  core block-complete pulse; core_hash valid same cycle.
REQ-012 core_hash  in  160  core chaining value {a,b,c,d,e}.
REQ-013 digest  out  160  final message digest, held until next done.
REQ-014 done  out  1  one-cycle pulse, digest valid.

Function
REQ-015 States SHALL be FILL, PAD, LEN, SEND, WAIT; reset state FILL.
REQ-016 s_ready SHALL be 1 only in FILL; one byte per cycle, written at byte position pos (0..63), pos and 61-bit byte count incremented.
REQ-017 Accepted byte landing at pos 63 SHALL move to SEND (non-final); if it was s_last, pad_pending set.
REQ-018 s_last beat (non-empty, pos<63 after write) or s_empty&s_last beat SHALL move to PAD; s_empty beats never write or count.
REQ-019 PAD (one cycle): byte pos = 0x80, bytes pos+1..63 = 0; if pos<=55, bytes 56..63 = bit length (count*8, 64-bit big-endian), mark final; else set len_pending; then SEND.
REQ-020 LEN (one cycle): bytes 0..55 = 0, 56..63 = bit length, mark final, then SEND.
REQ-021 SEND: blk_enable=1 exactly one cycle with blk_data/blk_index stable; then WAIT; blk_data/blk_index held constant through WAIT.
REQ-022 WAIT: ignore all until core_ready=1; then blk_index+1, pos=0, buffer cleared; next = final ? FILL : pad_pending ? PAD : len_pending ? LEN : FILL.
REQ-023 On core_ready in WAIT for final block: digest <= core_hash, done=1 next cycle, count/index/flags cleared so blk_index restarts at 1.
REQ-024 core_ready outside WAIT SHALL be ignored.
REQ-025 Two blocks after last byte iff (count mod 64) >= 56; one otherwise.
REQ-026 Byte count wraps modulo 2^61; length field = count*8 modulo 2^64.
REQ-027 FILL entered after done SHALL accept next message byte the following cycle; pending s_valid honoured without loss.

Reset
REQ-028 rst=0 at clk edge: state FILL, pos 0, count 0, blk_index 1, flags 0, blk_data 0, blk_enable 0, done 0, digest 0, s_ready 1 next cycle.
REQ-029 Reset mid-block or mid-WAIT SHALL abandon the message; core is reset concurrently by the system.
REQ-030 No output SHALL pulse during the cycle rst=0 is sampled.

Verification (paired with sha_1 core)
REQ-031 "abc" (3 bytes, last on 'c') -> one block, blk_data word0 = 0x61626380, word15 = 0x00000018; digest a9993e364706816aba3e25717850c26c9cd0d89d.
REQ-032 Empty message (s_valid,s_last,s_empty) -> word0 = 0x80000000, word15 = 0; digest da39a3ee5e6b4b0d3255bfef95601890afd80709.
REQ-033 56-byte "abcdbcdecdefdefg...nopq" -> two blocks (index 1,2), block 2 bytes 0..55 zero, word15 = 0x000001C0; digest 84983e441c3bd26ebaae4aa1f95129e5e54670f1.
REQ-034 64-byte message -> block 1 full data, block 2 word0 = 0x80000000, word15 = 0x00000200; blk_enable exactly two pulses.
REQ-035 Back-to-back "abc","abc" with s_valid held -> two done pulses, both digests a9993e36..., blk_index=1 for each.
REQ-036 rst=0 during WAIT of 56-byte message, then "abc" -> no done for aborted message; correct "abc" digest.
